// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (shift-add) / divide (restoring) unit producing HI and LO.
// Build option: define MULTDIV_EARLY_TERM_EN to end MULT as soon as the multiplier has no set bits left.
module mult_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_mult,
    input  logic              start_div,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero
);
    typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

    localparam int                  CNT_W     = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]    LAST_ITER = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0]   ZERO_W    = {DATA_W{1'b0}};
    localparam logic [2*DATA_W-1:0] ZERO_2W   = {(2*DATA_W){1'b0}};

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] acc_q, mcand_q;
    logic [DATA_W-1:0]   mplier_q, dvd_q, rem_q, dvsr_q;
    logic                neg_res_q, neg_rem_q, is_div_q, dbz_pend_q;
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic                busy_q, done_q, dbz_q;

    logic [DATA_W-1:0]   a_abs_s, b_abs_s, quot_s, rem_fix_s;
    logic [2*DATA_W-1:0] acc_d, prod_s;
    logic [DATA_W:0]     rem_shift_s, trial_s;
    logic                mult_skip_s;

    // Operand magnitudes, one datapath step, and sign correction of the finished magnitudes.
    always_comb begin
        a_abs_s     = op_a[DATA_W-1] ? (ZERO_W - op_a) : op_a;
        b_abs_s     = op_b[DATA_W-1] ? (ZERO_W - op_b) : op_b;
        acc_d       = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        rem_shift_s = {rem_q, dvd_q[DATA_W-1]};
        trial_s     = rem_shift_s - {1'b0, dvsr_q};
        prod_s      = neg_res_q ? (ZERO_2W - acc_q) : acc_q;
        quot_s      = neg_res_q ? (ZERO_W - dvd_q) : dvd_q;
        rem_fix_s   = neg_rem_q ? (ZERO_W - rem_q) : rem_q;
`ifdef MULTDIV_EARLY_TERM_EN
        mult_skip_s = (mplier_q == ZERO_W);
`else
        mult_skip_s = 1'b0;
`endif
    end

    // Control FSM with all datapath registers and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            acc_q      <= ZERO_2W;
            mcand_q    <= ZERO_2W;
            mplier_q   <= ZERO_W;
            dvd_q      <= ZERO_W;
            rem_q      <= ZERO_W;
            dvsr_q     <= ZERO_W;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            is_div_q   <= 1'b0;
            dbz_pend_q <= 1'b0;
            hi_q       <= ZERO_W;
            lo_q       <= ZERO_W;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            dbz_pend_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A pending divide-by-zero reports one edge after it was sampled; no new start meanwhile.
                    if (dbz_pend_q) begin
                        done_q <= 1'b1;
                        dbz_q  <= 1'b1;
                    end else if (start_mult) begin
                        acc_q     <= ZERO_2W;
                        mcand_q   <= {ZERO_W, a_abs_s};
                        mplier_q  <= b_abs_s;
                        neg_res_q <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
                        neg_rem_q <= op_a[DATA_W-1];
                        is_div_q  <= 1'b0;
                        cnt_q     <= {CNT_W{1'b0}};
                        busy_q    <= 1'b1;
                        state_q   <= MULT;
                    end else if (start_div) begin
                        if (op_b == ZERO_W) begin
                            dbz_pend_q <= 1'b1;
                        end else begin
                            dvd_q     <= a_abs_s;
                            rem_q     <= ZERO_W;
                            dvsr_q    <= b_abs_s;
                            neg_res_q <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
                            neg_rem_q <= op_a[DATA_W-1];
                            is_div_q  <= 1'b1;
                            cnt_q     <= {CNT_W{1'b0}};
                            busy_q    <= 1'b1;
                            state_q   <= DIV;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                MULT: begin
                    if (mult_skip_s) begin
                        state_q <= FIX;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + 1'b1;
                        state_q  <= (cnt_q == LAST_ITER) ? FIX : MULT;
                    end
                end
                DIV: begin
                    // The dividend register shifts out its bits and shifts in quotient bits.
                    if (!trial_s[DATA_W]) begin
                        rem_q <= trial_s[DATA_W-1:0];
                        dvd_q <= {dvd_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_shift_s[DATA_W-1:0];
                        dvd_q <= {dvd_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_q   <= cnt_q + 1'b1;
                    state_q <= (cnt_q == LAST_ITER) ? FIX : DIV;
                end
                FIX: begin
                    hi_q    <= is_div_q ? rem_fix_s : prod_s[2*DATA_W-1:DATA_W];
                    lo_q    <= is_div_q ? quot_s : prod_s[DATA_W-1:0];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
endmodule
